cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//   Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
//   Shares one memory port between instruction fetch and operand access, holds PC/IR/MDR.
//   Presents opcode to the opcode decoder and emits a one-cycle ex_strobe that gates
//   every datapath/PC commit. Owns run/halt control (start, HLT).
// PARAMETERS
//   ADDR_W    13   memory address width; must be <= DATA_W-3
//   DATA_W    16   instruction/data width
//   RESET_PC  0    PC value loaded on reset and on every start
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       begin execution at RESET_PC (honoured in IDLE/HALT only)
//   ac_zero    in   1       datapath accumulator == 0 (for JEZ)
//   mem_ack    in   1       memory completes current request this cycle
//   mem_rdata  in   DATA_W  read data, valid when mem_ack=1
//   mem_req    out  1       memory request, held until mem_ack
//   mem_we     out  1       1=write (STA), 0=read
//   mem_addr   out  ADDR_W  request address, stable while mem_req=1
//   pc         out  ADDR_W  program counter
//   ir         out  DATA_W  instruction register
//   opcode     out  3       ir[DATA_W-1:DATA_W-3], to decoder
//   mdr        out  DATA_W  operand captured on operand-read ack
//   ex_strobe  out  1       one-cycle commit enable for datapath/decoder outputs
//   busy       out  1       1 in FETCH/DECODE/MEM/EXEC
//   halted     out  1       1 in HALT
// BEHAVIOUR
//   - States: IDLE, FETCH, DECODE, MEM, EXEC, HALT. Outputs depend on registers only.
//   - Reset: state=IDLE, pc=RESET_PC, ir=0, mdr=0, mem_req=0, mem_we=0, mem_addr=0,
//     ex_strobe=0, busy=0, halted=0. rst wins over all inputs, incl. mid-transaction;
//     outstanding request is abandoned (mem_req low next cycle).
//   - IDLE: start -> FETCH, pc<=RESET_PC.
//   - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: ir<=mem_rdata,
//     pc<=pc+1 (mod 2^ADDR_W), -> DECODE. No ack: stay, outputs unchanged.
//   - DECODE (1 cycle): 000 LDA/010 ADD/011 SUB/001 STA -> MEM; 100 JMP/101 JEZ/110 LDI -> EXEC;
//     111 HLT -> HALT.
//   - MEM: mem_req=1, mem_addr=ir[ADDR_W-1:0], mem_we=1 only for STA. On mem_ack:
//     mdr<=mem_rdata for reads (mdr unchanged on STA), -> EXEC.
//   - EXEC (1 cycle): ex_strobe=1. JMP: pc<=ir[ADDR_W-1:0]. JEZ: pc<=target iff
//     ac_zero=1 (sampled this cycle). -> FETCH.
//   - HALT: halted=1, no requests. start -> FETCH, pc<=RESET_PC.
//   - start ignored while busy. mem_ack ignored when mem_req=0.
//   - Latency with zero-wait memory: non-memory instr 3 cycles, memory instr 4.
//     Each wait cycle adds 1. Exactly one memory transaction per FETCH/MEM visit.
// TESTING
//   1 rst; start; mem[0]=LDI 0x0005, mem[1]=HLT, ack same cycle -> ex_strobe in cycle 3,
//     fetch addr 1 in cycle 4, halted=1 in cycle 6, no mem_req after.
//   2 FETCH with ack delayed 3 cycles -> mem_req/mem_addr stable 4 cycles, ir unchanged until ack.
//   3 JMP 0x0123 -> next mem_addr=0x0123. JEZ 0x0040 with ac_zero=0 -> next fetch pc+1;
//     ac_zero=1 -> 0x0040.
//   4 STA 0x0040 -> single MEM request, mem_we=1, addr 0x0040, mdr unchanged;
//     ADD 0x0041 with rdata 0xBEEF -> mdr=0xBEEF at ex_strobe.
//   5 pc=0x1FFF fetches LDI -> next fetch addr 0x0000 (wrap).
//   6 rst during MEM wait -> next cycle mem_req=0, IDLE, pc=RESET_PC; start pulsed while busy
//     -> ignored, pc unaffected.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Owns PC/IR/MDR, the shared memory port and run/halt control.
module cpu_sequencer #(
    parameter int                ADDR_W   = 13,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ac_zero,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [DATA_W-1:0] mdr,
    output logic              ex_strobe,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JEZ = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] target;

    assign opcode = ir[DATA_W-1 -: 3];
    assign target = ir[ADDR_W-1:0];

    // State register plus PC/IR/MDR updates tied to the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            mdr   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) pc <= RESET_PC;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ack && opcode != OP_STA) mdr <= mem_rdata;
                end
                S_EXEC: begin
                    if (opcode == OP_JMP || (opcode == OP_JEZ && ac_zero)) pc <= target;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: state_nxt = S_MEM;
                    OP_JMP, OP_JEZ, OP_LDI:         state_nxt = S_EXEC;
                    OP_HLT:                         state_nxt = S_HALT;
                    default:                        state_nxt = S_HALT;
                endcase
            end
            S_MEM:    if (mem_ack) state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_FETCH;
            S_HALT:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so they never glitch on inputs
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        ex_strobe = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                busy     = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_STA);
                mem_addr = target;
                busy     = 1'b1;
            end
            S_EXEC: begin
                ex_strobe = 1'b1;
                busy      = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a small memory responder with programmable
// ack delay, and one task per scenario with hand-computed expectations.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ac_zero;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [12:0] pc;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic [15:0] mdr;
    logic        ex_strobe;
    logic        busy;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:8191];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [12:0] tr_addr [$];
    logic        tr_we [$];
    logic [15:0] ex_mdr [$];

    cpu_sequencer #(.ADDR_W(13), .DATA_W(16), .RESET_PC(13'h0000)) dut (
        .clk(clk), .rst(rst), .start(start), .ac_zero(ac_zero),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .pc(pc), .ir(ir),
        .opcode(opcode), .mdr(mdr), .ex_strobe(ex_strobe), .busy(busy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: answer the memory, then advance one cycle.
    task automatic tick();
        if (ex_strobe) ex_mdr.push_back(mdr);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 16'h0000 : mem[mem_addr];
                tr_addr.push_back(mem_addr);
                tr_we.push_back(mem_we);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        tr_addr.delete();
        tr_we.delete();
        ex_mdr.delete();
    endtask

    task automatic run_until_halt(input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, n);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8192; i++) mem[i] = 16'hE000;
        rst = 1'b1; start = 1'b0; ac_zero = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        rst = 1'b0;
        checks++;
        if ({mem_req, mem_we, ex_strobe, busy, halted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/strobe/busy/halted=%b required 00000",
                     {mem_req, mem_we, ex_strobe, busy, halted});
        end
        checks++;
        if (pc !== 13'h0 || ir !== 16'h0 || mdr !== 16'h0 || mem_addr !== 13'h0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h mdr=%h addr=%h required all 0", pc, ir, mdr, mem_addr);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b req=%b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_ldi_hlt();
        logic any_req;
        mem[0] = 16'hC005;
        mem[1] = 16'hE000;
        ack_delay = 0;
        clear_log();
        pulse_start();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'h0000 || mem_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL c1_fetch: req=%b addr=%h we=%b busy=%b required 1 0000 0 1", mem_req, mem_addr, mem_we, busy);
        end
        tick();
        checks++;
        if (ir !== 16'hC005 || pc !== 13'h0001 || opcode !== 3'b110 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL c2_decode: ir=%h pc=%h op=%b req=%b required c005 0001 110 0", ir, pc, opcode, mem_req);
        end
        tick();
        checks++;
        if (ex_strobe !== 1'b1) begin
            errors++;
            $display("FAIL c3_strobe: ex_strobe=%b required 1", ex_strobe);
        end
        tick();
        checks++;
        if (ex_strobe !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 13'h0001) begin
            errors++;
            $display("FAIL c4_fetch1: strobe=%b req=%b addr=%h required 0 1 0001", ex_strobe, mem_req, mem_addr);
        end
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL c6_halted: halted=%b busy=%b required 1 0", halted, busy);
        end
        any_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_req |= mem_req;
        end
        checks++;
        if (any_req !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_quiet: any_req=%b halted=%b required 0 1", any_req, halted);
        end
    endtask

    task automatic test_fetch_wait();
        logic stable;
        int   n;
        ack_delay = 3;
        clear_log();
        pulse_start();
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mem_req !== 1'b1 || mem_addr !== 13'h0000 || ir !== 16'hE000) stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait_stable: stable=%b required 1", stable);
        end
        checks++;
        if (mem_req !== 1'b0 || ir !== 16'hC005 || tr_addr.size() !== 1) begin
            errors++;
            $display("FAIL fetch_wait_ack: req=%b ir=%h acks=%0d required 0 c005 1", mem_req, ir, tr_addr.size());
        end
        ack_delay = 0;
        run_until_halt(50, n);
    endtask

    task automatic test_jumps();
        int n;
        mem[13'h0000] = 16'h8123;
        mem[13'h0123] = 16'hA040;
        mem[13'h0124] = 16'hA040;
        mem[13'h0040] = 16'hE000;
        clear_log();
        ac_zero = 1'b0;
        pulse_start();
        n = 0;
        while (tr_addr.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        ac_zero = 1'b1;
        run_until_halt(40, n);
        ac_zero = 1'b0;
        checks++;
        if (tr_addr.size() !== 4) begin
            errors++;
            $display("FAIL jump_count: fetches=%0d required 4", tr_addr.size());
        end else begin
            checks++;
            if (tr_addr[1] !== 13'h0123) begin
                errors++;
                $display("FAIL jmp_target: addr=%h required 0123", tr_addr[1]);
            end
            checks++;
            if (tr_addr[2] !== 13'h0124) begin
                errors++;
                $display("FAIL jez_not_taken: addr=%h required 0124", tr_addr[2]);
            end
            checks++;
            if (tr_addr[3] !== 13'h0040) begin
                errors++;
                $display("FAIL jez_taken: addr=%h required 0040", tr_addr[3]);
            end
        end
    endtask

    task automatic test_mem_ops();
        int n;
        mem[13'h0000] = 16'h2040;
        mem[13'h0001] = 16'h4041;
        mem[13'h0002] = 16'hE000;
        mem[13'h0041] = 16'hBEEF;
        clear_log();
        pulse_start();
        run_until_halt(60, n);
        checks++;
        if (n + 1 !== 11) begin
            errors++;
            $display("FAIL mem_latency: halted in cycle %0d required 11", n + 1);
        end
        checks++;
        if (tr_addr.size() !== 5) begin
            errors++;
            $display("FAIL mem_tr_count: transactions=%0d required 5", tr_addr.size());
        end else begin
            checks++;
            if (tr_addr[1] !== 13'h0040 || tr_we[1] !== 1'b1 || tr_we[0] !== 1'b0) begin
                errors++;
                $display("FAIL sta_write: addr=%h we=%b fetch_we=%b required 0040 1 0", tr_addr[1], tr_we[1], tr_we[0]);
            end
            checks++;
            if (tr_addr[3] !== 13'h0041 || tr_we[3] !== 1'b0 || tr_addr[2] !== 13'h0001) begin
                errors++;
                $display("FAIL add_read: addr=%h we=%b fetch=%h required 0041 0 0001", tr_addr[3], tr_we[3], tr_addr[2]);
            end
        end
        checks++;
        if (ex_mdr.size() !== 2) begin
            errors++;
            $display("FAIL strobe_count: strobes=%0d required 2", ex_mdr.size());
        end else begin
            checks++;
            if (ex_mdr[0] !== 16'h0000 || ex_mdr[1] !== 16'hBEEF) begin
                errors++;
                $display("FAIL mdr_at_strobe: sta=%h add=%h required 0000 beef", ex_mdr[0], ex_mdr[1]);
            end
        end
    endtask

    task automatic test_pc_wrap();
        int n;
        mem[13'h0000] = 16'h9FFF;
        mem[13'h1FFF] = 16'hC005;
        clear_log();
        pulse_start();
        n = 0;
        while (tr_addr.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (tr_addr.size() < 3) begin
            errors++;
            $display("FAIL wrap_timeout: fetches=%0d required 3", tr_addr.size());
        end else begin
            checks++;
            if (tr_addr[1] !== 13'h1FFF || tr_addr[2] !== 13'h0000) begin
                errors++;
                $display("FAIL pc_wrap: fetches %h,%h required 1fff,0000", tr_addr[1], tr_addr[2]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        int n;
        mem[13'h0000] = 16'h0010;
        ack_delay = 3;
        clear_log();
        pulse_start();
        n = 0;
        while (!(mem_req && mem_addr == 13'h0010) && n < 40) begin
            tick();
            n++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 13'h0010 || pc !== 13'h0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: req=%b addr=%h pc=%h busy=%b required 1 0010 0001 1", mem_req, mem_addr, pc, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || pc !== 13'h0000 || mem_addr !== 13'h0000) begin
            errors++;
            $display("FAIL rst_mid_mem: req=%b busy=%b halted=%b pc=%h addr=%h required 0 0 0 0000 0000", mem_req, busy, halted, pc, mem_addr);
        end
        ack_delay = 0;
    endtask

    initial begin
        test_reset();
        test_ldi_hlt();
        test_fetch_wait();
        test_jumps();
        test_mem_ops();
        test_pc_wrap();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
